via_timer: RTL and testbench

65C22-style 16-bit interval timer peripheral that responds to 65C02 bus cycles on the system data/address bus. External address decode supplies a chip select. Software loads a latch and starts the counter, then gets a maskable interrupt on underflow in one-shot or free-run mode. Each bus cycle is one `phi2` period and is committed on the rising edge of `phi2` that ends it.

---
 rtl/via_timer.sv | 140 ++++++++++++++
 tb/tb_via_timer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/via_timer.sv
// via_timer: 65C22-style 16-bit interval timer (one-shot / free-run) with maskable underflow IRQ; VIA_TIMER_PB7_EN adds the PB7 toggle output.
// Latency: writes commit at the phi2 edge ending the bus cycle; read data and irqb are combinational from current state.
// Backpressure: none, every bus cycle completes in exactly one phi2 period.
module via_timer (
    input  logic       phi2,
    input  logic       rst,
    input  logic       cs,
    input  logic [2:0] rs,
    input  logic       rwb,
    inout  wire  [7:0] data,
    output logic       irqb
`ifdef VIA_TIMER_PB7_EN
    ,
    output logic       pb7
`endif
);

    logic [15:0] counter;
    logic [15:0] latch;
    logic        free_run;
    logic        ifr0;
    logic        ier0;
    logic        armed;
    logic        wr;
    logic        rd;
    logic        t1ch_wr;
    logic        ctrl_wr;
    logic        underflow;
    logic        flag_set;
    logic        flag_clr;
    logic [7:0]  ctrl_dat;
    logic [7:0]  rd_dat;

    assign wr        = cs & ~rwb;
    assign rd        = cs & rwb;
    assign t1ch_wr   = wr && (rs == 3'd1);
    assign ctrl_wr   = wr && (rs == 3'd4);
    assign underflow = (counter == 16'h0000);
    // A T1CH write in the underflow cycle suppresses the flag entirely.
    assign flag_set  = underflow & (free_run | armed) & ~t1ch_wr;
    assign flag_clr  = (rd && (rs == 3'd0)) || (wr && (rs == 3'd5) && data[0]);

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            counter <= 16'hFFFF;
        end else if (t1ch_wr) begin
            counter <= {data, latch[7:0]};
        end else if (underflow && free_run) begin
            counter <= latch;
        end else begin
            counter <= counter - 16'd1;
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            latch <= 16'hFFFF;
        end else if (wr) begin
            case (rs)
                3'd0, 3'd2: latch[7:0]  <= data;
                3'd1, 3'd3: latch[15:8] <= data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            ifr0     <= 1'b0;
            armed    <= 1'b0;
            free_run <= 1'b0;
            ier0     <= 1'b0;
        end else begin
            if (t1ch_wr) begin
                ifr0  <= 1'b0;
                armed <= 1'b1;
            end else begin
                if (flag_set) begin
                    ifr0 <= 1'b1;
                end else if (flag_clr) begin
                    ifr0 <= 1'b0;
                end
                if (underflow && !free_run) begin
                    armed <= 1'b0;
                end
            end
            if (ctrl_wr) begin
                free_run <= data[0];
            end
            if (wr && (rs == 3'd6)) begin
                ier0 <= data[0];
            end
        end
    end

`ifdef VIA_TIMER_PB7_EN
    logic pb7_en;
    logic pb7_q;

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            pb7_en <= 1'b0;
            pb7_q  <= 1'b1;
        end else begin
            if (ctrl_wr) begin
                pb7_en <= data[1];
            end
            if (ctrl_wr && data[1] && !pb7_en) begin
                pb7_q <= 1'b1;
            end else if (pb7_en && flag_set) begin
                pb7_q <= ~pb7_q;
            end
        end
    end

    // Pin is forced high whenever the toggle function is disabled.
    assign pb7      = pb7_q | ~pb7_en;
    assign ctrl_dat = {6'b0, pb7_en, free_run};
`else
    assign ctrl_dat = {7'b0, free_run};
`endif

    always_comb begin
        rd_dat = 8'h00;
        case (rs)
            3'd0: rd_dat = counter[7:0];
            3'd1: rd_dat = counter[15:8];
            3'd2: rd_dat = latch[7:0];
            3'd3: rd_dat = latch[15:8];
            3'd4: rd_dat = ctrl_dat;
            3'd5: rd_dat = {ifr0 & ier0, 6'b0, ifr0};
            3'd6: rd_dat = {7'b0, ier0};
            default: rd_dat = 8'h00;
        endcase
    end

    assign data = rd ? rd_dat : 8'hzz;
    assign irqb = ~(ifr0 & ier0);

endmodule

// File: tb/tb_via_timer.sv
// Self-checking bench for via_timer: reset/bus vector table, hand-written timing sequences, randomized run against a reference model.
module tb_via_timer;

    logic       phi2 = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic [2:0] rs = 3'd0;
    logic       rwb = 1'b1;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dat = 8'h00;
    wire  [7:0] data;
    logic       irqb;
    logic [7:0] rd_s;
    logic       irq_s;
`ifdef VIA_TIMER_PB7_EN
    logic       pb7_w;
    logic       pb_s;
`endif

    int n_chk = 0;
    int n_pass = 0;

    assign data = tb_oe ? tb_dat : 8'hzz;

    via_timer dut (
        .phi2 (phi2),
        .rst  (rst),
        .cs   (cs),
        .rs   (rs),
        .rwb  (rwb),
        .data (data),
        .irqb (irqb)
`ifdef VIA_TIMER_PB7_EN
        ,
        .pb7  (pb7_w)
`endif
    );

    always #5 phi2 = ~phi2;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // One bus cycle: drive after the rising edge, sample at the falling edge, end just after the next rising edge.
    task automatic cyc(input bit c, input bit w, input logic [2:0] r, input logic [7:0] d);
        cs = c; rwb = w; rs = r; tb_dat = d; tb_oe = !w;
        @(negedge phi2);
        rd_s  = data;
        irq_s = irqb;
`ifdef VIA_TIMER_PB7_EN
        pb_s  = pb7_w;
`endif
        @(posedge phi2);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 3'd0, 8'h00);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        @(posedge phi2);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: integer counter/latch and flag bits stepped once per bus cycle.
    int m_cnt, m_latch;
    bit m_fr, m_pe, m_flag, m_ier, m_armed, m_tog;

    function automatic void m_reset();
        m_cnt = 65535; m_latch = 65535;
        m_fr = 0; m_pe = 0; m_flag = 0; m_ier = 0; m_armed = 0; m_tog = 1;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] r);
        case (r)
            3'd0: return 8'(m_cnt % 256);
            3'd1: return 8'(m_cnt / 256);
            3'd2: return 8'(m_latch % 256);
            3'd3: return 8'(m_latch / 256);
            3'd4: return {6'b0, m_pe, m_fr};
            3'd5: return {m_flag & m_ier, 6'b0, m_flag};
            3'd6: return {7'b0, m_ier};
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_step(input bit c, input bit w, input logic [2:0] r, input logic [7:0] d);
        bit uf, t1ch, fire;
        int old_latch;
        uf        = (m_cnt == 0);
        t1ch      = c && !w && (r == 3'd1);
        fire      = uf && (m_fr || m_armed) && !t1ch;
        old_latch = m_latch;
        if (uf && m_fr) m_cnt = old_latch;
        else m_cnt = (m_cnt + 65535) % 65536;
        if (fire) begin
            m_flag = 1;
            if (!m_fr) m_armed = 0;
            if (m_pe) m_tog = !m_tog;
        end
        if (c && w && r == 3'd0 && !fire) m_flag = 0;
        if (c && !w) begin
            case (r)
                3'd0, 3'd2: m_latch = (m_latch / 256) * 256 + int'(d);
                3'd1: begin
                    m_latch = int'(d) * 256 + old_latch % 256;
                    m_cnt   = int'(d) * 256 + old_latch % 256;
                    m_flag  = 0;
                    m_armed = 1;
                end
                3'd3: m_latch = int'(d) * 256 + m_latch % 256;
                3'd4: begin
`ifdef VIA_TIMER_PB7_EN
                    if (d[1] && !m_pe) m_tog = 1;
                    m_pe = d[1];
`endif
                    m_fr = d[0];
                end
                3'd5: if (d[0] && !fire) m_flag = 0;
                3'd6: m_ier = d[0];
                default: ;
            endcase
        end
    endfunction

    typedef struct {
        bit         c;
        bit         w;
        logic [2:0] r;
        logic [7:0] d;
        bit         chk;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int found, lows;
        logic [7:0] fr_exp[5];
        bit c, w;
        logic [2:0] r;
        logic [7:0] d, e_rd;
        bit e_irq;

        tbl[0]  = '{1, 1, 3'd7, 8'h00, 1, 8'h00};
        tbl[1]  = '{1, 1, 3'd2, 8'h00, 1, 8'hFF};
        tbl[2]  = '{1, 1, 3'd3, 8'h00, 1, 8'hFF};
        tbl[3]  = '{1, 1, 3'd4, 8'h00, 1, 8'h00};
        tbl[4]  = '{1, 1, 3'd5, 8'h00, 1, 8'h00};
        tbl[5]  = '{1, 1, 3'd6, 8'h00, 1, 8'h00};
        tbl[6]  = '{1, 1, 3'd1, 8'h00, 1, 8'hFF};
        tbl[7]  = '{0, 0, 3'd6, 8'h01, 0, 8'h00};
        tbl[8]  = '{1, 1, 3'd6, 8'h00, 1, 8'h00};
        tbl[9]  = '{1, 0, 3'd6, 8'h01, 0, 8'h00};
        tbl[10] = '{1, 1, 3'd6, 8'h00, 1, 8'h01};
        tbl[11] = '{1, 0, 3'd2, 8'h34, 0, 8'h00};
        tbl[12] = '{1, 1, 3'd2, 8'h00, 1, 8'h34};
        tbl[13] = '{1, 0, 3'd3, 8'h12, 0, 8'h00};
        tbl[14] = '{1, 1, 3'd3, 8'h00, 1, 8'h12};
        tbl[15] = '{1, 0, 3'd7, 8'hFF, 0, 8'h00};
        tbl[16] = '{1, 1, 3'd7, 8'h00, 1, 8'h00};
        fr_exp = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03};

        repeat (2) @(posedge phi2);
        #1;
        rst = 1'b0;

        // One-shot: interrupt 6 edges after the T1CH write, cleared by a T1CL read, never repeated.
        cyc(1, 0, 3'd6, 8'h01);
        cyc(1, 0, 3'd0, 8'h05);
        cyc(1, 0, 3'd1, 8'h00);
        found = 0;
        for (int j = 1; j <= 20; j++) begin
            idle();
            if (found == 0 && !irq_s) found = j;
        end
        chk("oneshot_irq_delay", found, 7);
        cyc(1, 1, 3'd0, 8'h00);
        chk("oneshot_irq_before_clear", int'(irq_s), 0);
        idle();
        chk("oneshot_irq_after_t1cl_read", int'(irq_s), 1);
        lows = 0;
        for (int j = 0; j < 70000; j++) begin
            idle();
            if (!irq_s) lows++;
        end
        chk("oneshot_no_second_irq", lows, 0);
        cyc(1, 0, 3'd1, 8'h00);
        repeat (8) idle();
        chk("oneshot_rearm_irq", int'(irq_s), 0);

        // Asynchronous reset mid-cycle must release irqb before any clock edge.
        rst = 1'b1;
        #1;
        chk("async_reset_irqb", int'(irqb), 1);
        @(posedge phi2);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
            if (tbl[i].chk) chk($sformatf("tbl%0d_rd", i), int'(rd_s), int'(tbl[i].exp));
            chk($sformatf("tbl%0d_irqb", i), int'(irq_s), 1);
        end

        // Bus released while deselected: the bench's own drive must be seen unaltered.
        cs = 0; rwb = 1; rs = 3'd2; tb_oe = 1; tb_dat = 8'h00;
        @(negedge phi2);
        chk("bus_hiz_when_deselected", int'(data), 0);
        @(posedge phi2);
        #1;
        tb_oe = 0;

        // Free-run with latch 3, flag priority and T1CH write during underflow.
        hard_reset();
        cyc(1, 0, 3'd4, 8'h01);
        cyc(1, 0, 3'd2, 8'h03);
        cyc(1, 0, 3'd3, 8'h00);
        cyc(1, 0, 3'd1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 3'd0, 8'h00);
            chk($sformatf("freerun_t1cl_%0d", i), int'(rd_s), int'(fr_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 3'd5, 8'h00);
            chk($sformatf("freerun_ifr_%0d", i), int'(rd_s), (i == 3) ? 8'h01 : 8'h00);
        end
        cyc(1, 0, 3'd6, 8'h01);
        cyc(1, 1, 3'd5, 8'h00);
        chk("ifr_with_ier", int'(rd_s), 8'h81);
        chk("irqb_with_ier", int'(irq_s), 0);
        cyc(1, 0, 3'd5, 8'h01);
        cyc(1, 1, 3'd5, 8'h00);
        chk("ifr_set_beats_clear", int'(rd_s), 8'h81);
        cyc(1, 0, 3'd5, 8'h01);
        cyc(1, 1, 3'd5, 8'h00);
        chk("ifr_cleared", int'(rd_s), 8'h00);
        chk("irqb_cleared", int'(irq_s), 1);
        cyc(1, 0, 3'd1, 8'h20);
        cyc(1, 1, 3'd5, 8'h00);
        chk("t1ch_beats_underflow_ifr", int'(rd_s), 8'h00);
        cyc(1, 1, 3'd0, 8'h00);
        chk("t1ch_beats_underflow_cntl", int'(rd_s), 8'h02);
        cyc(1, 1, 3'd1, 8'h00);
        chk("t1ch_beats_underflow_cnth", int'(rd_s), 8'h20);

`ifdef VIA_TIMER_PB7_EN
        hard_reset();
        cyc(1, 0, 3'd2, 8'h01);
        cyc(1, 0, 3'd3, 8'h00);
        cyc(1, 0, 3'd4, 8'h03);
        cyc(1, 0, 3'd1, 8'h00);
        for (int j = 0; j < 6; j++) begin
            idle();
            chk($sformatf("pb7_toggle_%0d", j), int'(pb_s), ((j / 2) % 2 == 0) ? 1 : 0);
        end
        cyc(1, 0, 3'd4, 8'h01);
        chk("pb7_low_before_disable", int'(pb_s), 0);
        for (int j = 0; j < 4; j++) begin
            idle();
            chk($sformatf("pb7_hold_%0d", j), int'(pb_s), 1);
        end
`endif

        // Randomized traffic against the reference model.
        hard_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 3) != 0);
            r = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            if (!w && (r == 3'd1 || r == 3'd3)) d = 8'($urandom_range(0, 1) == 0 ? 0 : d % 2);
            if (!w && (r == 3'd0 || r == 3'd2)) d = 8'($urandom_range(0, 15));
            e_rd  = m_read(r);
            e_irq = !(m_flag && m_ier);
            cyc(c, w, r, d);
            if (c && w) chk($sformatf("rand%0d_rd_rs%0d", i, r), int'(rd_s), int'(e_rd));
            chk($sformatf("rand%0d_irqb", i), int'(irq_s), int'(e_irq));
`ifdef VIA_TIMER_PB7_EN
            chk($sformatf("rand%0d_pb7", i), int'(pb_s), m_pe ? int'(m_tog) : 1);
`endif
            m_step(c, w, r, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
